// File: rtl/xbus_initiator.sv
// Single-outstanding Xbus master: client command/response handshake to Xbus cycles.
// Optional no-ack watchdog enabled by defining XBUS_INIT_TIMEOUT_EN.
module xbus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_req,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_decode
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        cmd_ready_nxt, rsp_valid_nxt, bus_req_nxt, bus_write_nxt;
  logic [21:0] bus_addr_nxt;
  logic [31:0] bus_wdata_nxt, rsp_rdata_nxt;
  logic        unused_decode;

  // Decode is only of interest to a future watchdog refinement.
  assign unused_decode = bus_decode & (TIMEOUT != 0);

`ifdef XBUS_INIT_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] counter, counter_nxt;
  logic             rsp_timeout_q, rsp_timeout_nxt;

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    cmd_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    bus_req_nxt   = bus_req;
    bus_write_nxt = bus_write;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
`ifdef XBUS_INIT_TIMEOUT_EN
    counter_nxt     = counter;
    rsp_timeout_nxt = rsp_timeout_q;
`endif
    case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          bus_addr_nxt  = cmd_addr;
          bus_wdata_nxt = cmd_wdata;
          bus_write_nxt = cmd_write;
          bus_req_nxt   = 1'b1;
          cmd_ready_nxt = 1'b0;
`ifdef XBUS_INIT_TIMEOUT_EN
          counter_nxt   = '0;
`endif
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          rsp_rdata_nxt = bus_write ? 32'd0 : bus_rdata;
          rsp_valid_nxt = 1'b1;
          bus_req_nxt   = 1'b0;
          bus_write_nxt = 1'b0;
`ifdef XBUS_INIT_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
`endif
          state_nxt     = DRAIN;
        end
`ifdef XBUS_INIT_TIMEOUT_EN
        else if (counter == CNT_LAST) begin
          rsp_rdata_nxt   = 32'd0;
          rsp_valid_nxt   = 1'b1;
          rsp_timeout_nxt = 1'b1;
          bus_req_nxt     = 1'b0;
          state_nxt       = DRAIN;
        end else begin
          counter_nxt = counter + 1'b1;
        end
`endif
      end
      DRAIN: begin
        // Wait out the responder's ack tail so it cannot complete the next command.
        if (!bus_ack) begin
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= 22'd0;
      bus_wdata <= 32'd0;
`ifdef XBUS_INIT_TIMEOUT_EN
      counter       <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      bus_req   <= bus_req_nxt;
      bus_write <= bus_write_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
`ifdef XBUS_INIT_TIMEOUT_EN
      counter       <= counter_nxt;
      rsp_timeout_q <= rsp_timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_xbus_initiator.sv
// Bench for xbus_initiator: responder model, transaction-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_xbus_initiator;
`ifdef XBUS_INIT_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [21:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_req, bus_write, bus_ack, bus_decode;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [3:0] extra_sel;
  logic       present_sel;

  always #5 clk = ~clk;

  xbus_initiator #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_req(bus_req), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_decode(bus_decode)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, got, want);
    end
  endtask

  // Responder: data registered the cycle after req&decode, ack two cycles after decode,
  // with an optional number of extra wait cycles before decode is honoured.
  logic [31:0] mem [16];
  logic [31:0] data_q, junk;
  logic        p1, present_q;
  logic [3:0]  wait_cnt, extra_q;
  logic        go;

  assign bus_decode = bus_req & present_q;
  assign go         = bus_decode && (wait_cnt >= extra_q);
  assign bus_rdata  = bus_ack ? data_q : junk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    junk <= $urandom;
    if (reset) begin
      p1        <= 1'b0;
      bus_ack   <= 1'b0;
      data_q    <= 32'd0;
      wait_cnt  <= 4'd0;
      extra_q   <= 4'd0;
      present_q <= 1'b1;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[5] <= 32'h0000_00A5;
    end else begin
      if (!bus_req) begin
        wait_cnt  <= 4'd0;
        extra_q   <= extra_sel;
        present_q <= present_sel;
      end else if (bus_decode && wait_cnt < extra_q) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      p1      <= go;
      bus_ack <= p1;
      if (go) begin
        data_q <= mem[bus_addr[3:0]];
        if (bus_write) mem[bus_addr[3:0]] <= bus_wdata;
      end
    end
  end

  // Reference model: one transaction at a time, expected read data taken from the
  // responder's storage at accept time, completion on ack, re-arm once the ack tail is gone.
  logic        m_ready, m_rv, m_rto, m_req, m_wr, m_busy, m_tail;
  logic [21:0] m_addr;
  logic [31:0] m_wdata, m_rdata, m_exp;
  int          m_age;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b0; m_rv = 1'b0; m_rto = 1'b0; m_req = 1'b0; m_wr = 1'b0;
      m_busy = 1'b0; m_tail = 1'b0; m_addr = 22'd0; m_wdata = 32'd0;
      m_rdata = 32'd0; m_exp = 32'd0; m_age = 0;
    end else begin
      m_rv = 1'b0;
      if (m_tail) begin
        if (!bus_ack) begin
          m_tail  = 1'b0;
          m_ready = 1'b1;
        end
      end else if (m_busy) begin
        if (bus_ack) begin
          m_rv = 1'b1; m_rto = 1'b0; m_rdata = m_exp;
          m_req = 1'b0; m_wr = 1'b0; m_busy = 1'b0; m_tail = 1'b1;
        end
`ifdef XBUS_INIT_TIMEOUT_EN
        else if (m_age == TMO - 1) begin
          m_rv = 1'b1; m_rto = 1'b1; m_rdata = 32'd0;
          m_req = 1'b0; m_busy = 1'b0; m_tail = 1'b1;
        end else begin
          m_age++;
        end
`endif
      end else if (cmd_valid && m_ready) begin
        m_addr = cmd_addr; m_wdata = cmd_wdata; m_wr = cmd_write;
        m_req = 1'b1; m_ready = 1'b0; m_busy = 1'b1; m_age = 0;
        m_exp = cmd_write ? 32'd0 : mem[cmd_addr[3:0]];
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("bus_req", 32'(bus_req), 32'(m_req));
    chk("bus_addr", 32'(bus_addr), 32'(m_addr));
    chk("bus_wdata", bus_wdata, m_wdata);
    if (m_req) chk("bus_write", 32'(bus_write), 32'(m_wr));
    if (m_rv) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
    end
  end

  // Present one command, wait for its response and for cmd_ready to return.
  task automatic xact(input logic w, input logic [21:0] a, input logic [31:0] d,
                      input logic [3:0] ex, input logic pres,
                      output int lat, output logic [31:0] rd, output logic to, output int rdy);
    int acc;
    acc = -1; lat = -1; rd = 32'd0; to = 1'b0; rdy = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    extra_sel = ex; present_sel = pres;
    for (int i = 0; i < 400 && acc < 0; i++) begin
      @(posedge clk);
      if (cmd_ready) acc = cyc;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (acc < 0) begin
      chk("accept_wait", 32'(cmd_ready), 32'd1);
      return;
    end
    chk("req_after_accept", 32'(bus_req), 32'd1);
    chk("write_with_req", 32'(bus_write), 32'(w));
    for (int i = 0; i < 400 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = cyc - 1 - acc; rd = rsp_rdata; to = rsp_timeout;
      end
    end
    for (int i = 1; i < 400 && rdy < 0; i++) begin
      @(posedge clk); #1;
      if (cmd_ready) rdy = i;
    end
  endtask

  int          lat, rdy, acc1, acc2, pulses;
  logic [31:0] rd;
  logic        to, acc_b;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 22'd0; cmd_wdata = 32'd0;
    extra_sel = 4'd0; present_sel = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_req", 32'(bus_req), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_addr", 32'(bus_addr), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    xact(1'b0, 22'o17772045, 32'd0, 4'd0, 1'b1, lat, rd, to, rdy);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'h0000_00A5);
    chk("rd_timeout", 32'(to), 32'd0);
    chk("rd_ready_return", 32'(rdy), 32'd3);

    xact(1'b1, 22'o17772045, 32'h5, 4'd0, 1'b1, lat, rd, to, rdy);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_csr", 32'(mem[5][3:0]), 32'h5);
    chk("wr_ready_return", 32'(rdy), 32'd3);

    xact(1'b0, 22'o17772045, 32'd0, 4'd0, 1'b1, lat, rd, to, rdy);
    chk("rdback_data", rd, 32'h5);

    xact(1'b0, 22'o3, 32'd0, 4'd2, 1'b1, lat, rd, to, rdy);
    chk("slow_latency", 32'(lat), 32'd5);
    chk("slow_data", rd, 32'h1000_0003);

    // cmd_valid held across two commands
    acc1 = -1; acc2 = -1; pulses = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'o17772045; extra_sel = 4'd0; present_sel = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (cmd_valid && cmd_ready) begin
        if (acc1 < 0) acc1 = cyc; else acc2 = cyc;
      end
      #1;
      if (rsp_valid) pulses++;
      @(negedge clk);
      if (acc2 >= 0) cmd_valid = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_gap", 32'(acc2 - acc1), 32'd7);

    // reset while BUSY
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 22'o3; extra_sel = 4'd5;
    acc1 = -1;
    for (int i = 0; i < 20 && acc1 < 0; i++) begin
      @(posedge clk);
      if (cmd_ready) acc1 = cyc;
    end
    @(negedge clk); cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("busy_reset_req", 32'(bus_req), 32'd0);
    chk("busy_reset_rsp", 32'(rsp_valid), 32'd0);
    chk("busy_reset_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    xact(1'b0, 22'o17772045, 32'd0, 4'd0, 1'b1, lat, rd, to, rdy);
    chk("post_reset_latency", 32'(lat), 32'd3);
    chk("post_reset_data", rd, 32'h0000_00A5);

`ifdef XBUS_INIT_TIMEOUT_EN
    xact(1'b0, 22'o0, 32'd0, 4'd0, 1'b0, lat, rd, to, rdy);
    chk("tmo_latency", 32'(lat), 32'd16);
    chk("tmo_flag", 32'(to), 32'd1);
    chk("tmo_rdata", rd, 32'd0);
    chk("tmo_ready_return", 32'(rdy), 32'd1);
    xact(1'b0, 22'o3, 32'd0, 4'd13, 1'b1, lat, rd, to, rdy);
    chk("ack_at_limit_latency", 32'(lat), 32'd16);
    chk("ack_at_limit_flag", 32'(to), 32'd0);
    chk("ack_at_limit_data", rd, 32'h1000_0003);
    xact(1'b0, 22'o3, 32'd0, 4'd14, 1'b1, lat, rd, to, rdy);
    chk("late_ack_flag", 32'(to), 32'd1);
    chk("late_ack_ready_return", 32'(rdy), 32'd3);
`endif

    // random traffic, payload churn while not ready, occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      acc_b = cmd_valid && cmd_ready && !reset;
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      if (!cmd_valid || acc_b) begin
        cmd_valid   = ($urandom_range(0, 2) != 0);
        cmd_write   = $urandom_range(0, 1) == 1;
        cmd_addr    = 22'($urandom);
        cmd_wdata   = $urandom;
        extra_sel   = 4'($urandom_range(0, 3));
`ifdef XBUS_INIT_TIMEOUT_EN
        present_sel = ($urandom_range(0, 3) != 0);
`else
        present_sel = 1'b1;
`endif
      end else if ($urandom_range(0, 3) == 0) begin
        cmd_write = $urandom_range(0, 1) == 1;
        cmd_addr  = 22'($urandom);
        cmd_wdata = $urandom;
      end
    end
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
